// File: rtl/lsu_pkg.sv
// Shared types, address map and lane helpers for the sized load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } lsu_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } lsu_state_e;

  typedef enum logic [2:0] {
    RG_DMEM, RG_LEDR, RG_LEDG, RG_HEXLO, RG_HEXHI, RG_LCD, RG_SW, RG_NONE
  } lsu_region_e;

  localparam logic [31:0] BASE_DMEM  = 32'h0000_0000;
  localparam logic [31:0] BASE_LEDR  = 32'h1000_0000;
  localparam logic [31:0] BASE_LEDG  = 32'h1000_1000;
  localparam logic [31:0] BASE_HEXLO = 32'h1000_2000;
  localparam logic [31:0] BASE_HEXHI = 32'h1000_3000;
  localparam logic [31:0] BASE_LCD   = 32'h1000_4000;
  localparam logic [31:0] BASE_SW    = 32'h1001_0000;

  // Captured request; everything the response cycle needs.
  typedef struct packed {
    logic [31:0] addr;
    lsu_size_e   size;
    logic        uns;
    logic        wren;
    logic [31:0] st_data;
    lsu_region_e region;
    logic        err;
  } lsu_req_t;

  // IO registers are matched on the word address so sub-word accesses hit them.
  function automatic lsu_region_e decode(input logic [31:0] a, input logic [31:0] dmem_bytes);
    lsu_region_e r;
    r = RG_NONE;
    if (a < dmem_bytes)                      r = RG_DMEM;
    else if (a[31:2] == BASE_LEDR[31:2])     r = RG_LEDR;
    else if (a[31:2] == BASE_LEDG[31:2])     r = RG_LEDG;
    else if (a[31:2] == BASE_HEXLO[31:2])    r = RG_HEXLO;
    else if (a[31:2] == BASE_HEXHI[31:2])    r = RG_HEXHI;
    else if (a[31:2] == BASE_LCD[31:2])      r = RG_LCD;
    else if (a[31:2] == BASE_SW[31:2])       r = RG_SW;
    return r;
  endfunction

  function automatic logic [3:0] byte_en(input lsu_size_e sz, input logic [1:0] off);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data so every enabled lane sees its bytes.
  function automatic logic [31:0] lane_data(input lsu_size_e sz, input logic [31:0] wd);
    logic [31:0] d;
    case (sz)
      SZ_BYTE: d = {4{wd[7:0]}};
      SZ_HALF: d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                       input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                          input lsu_size_e sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      SZ_WORD: r = w;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_sized_if.sv
// Request/response bus between a core and the load/store unit.
interface lsu_sized_if;
  logic        i_req_vld;
  logic        o_req_rdy;
  logic [31:0] i_lsu_addr;
  logic        i_lsu_wren;
  logic [1:0]  i_lsu_size;
  logic        i_lsu_unsigned;
  logic [31:0] i_st_data;
  logic        o_rsp_vld;
  logic [31:0] o_ld_data;
  logic        o_rsp_err;

  modport slave (
    input  i_req_vld, i_lsu_addr, i_lsu_wren, i_lsu_size, i_lsu_unsigned, i_st_data,
    output o_req_rdy, o_rsp_vld, o_ld_data, o_rsp_err
  );

  modport master (
    output i_req_vld, i_lsu_addr, i_lsu_wren, i_lsu_size, i_lsu_unsigned, i_st_data,
    input  o_req_rdy, o_rsp_vld, o_ld_data, o_rsp_err
  );
endinterface

// File: rtl/dmem_bytelane.sv
// Data RAM built from four independent byte lanes with synchronous read.
module dmem_bytelane #(
  parameter int DMEM_WORDS = 2048,
  parameter int AW         = $clog2(DMEM_WORDS)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [AW-1:0]    addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem [DMEM_WORDS];
    logic [7:0] rd_q;

    // Byte write and registered read for this lane; contents are never reset.
    always_ff @(posedge clk) begin
      if (we && be[i]) mem[addr] <= wdata[i*8 +: 8];
      if (en)          rd_q      <= mem[addr];
    end

    assign rdata[i*8 +: 8] = rd_q;
  end

endmodule

// File: rtl/lsu_sized.sv
// Two-cycle sized load/store unit: data RAM plus memory-mapped IO registers.
module lsu_sized
  import lsu_pkg::*;
#(
  parameter int DMEM_WORDS = 2048,
  parameter int NUM_HEX    = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  lsu_sized_if.slave               bus,
  output logic [31:0]              o_io_ledr,
  output logic [31:0]              o_io_ledg,
  output logic [31:0]              o_io_lcd,
  output logic [NUM_HEX-1:0][6:0]  o_io_hex,
  input  logic [31:0]              i_io_sw
);

  localparam int          AW         = $clog2(DMEM_WORDS);
  localparam logic [31:0] DMEM_BYTES = 32'(4 * DMEM_WORDS);

  lsu_state_e  state_q, state_d;
  lsu_req_t    cap_q;
  logic [31:0] ledr_q, ledg_q, hexlo_q, hexhi_q, lcd_q;
  logic [31:0] sw_meta_q, sw_sync_q;
  logic [31:0] dmem_rdata;

  // Request decode happens at acceptance so writes can commit on that edge.
  lsu_size_e   size_in;
  lsu_region_e region_in;
  logic        accept, mis_in, err_in, do_wr;
  logic [3:0]  be_in;
  logic [31:0] wd_in;

  assign size_in   = lsu_size_e'(bus.i_lsu_size);
  assign accept    = bus.i_req_vld && (state_q == ST_IDLE);
  assign region_in = decode(bus.i_lsu_addr, DMEM_BYTES);
  assign mis_in    = ((size_in == SZ_HALF) && bus.i_lsu_addr[0]) ||
                     ((size_in == SZ_WORD) && (bus.i_lsu_addr[1:0] != 2'b00));
  assign err_in    = (size_in == SZ_ILL) || mis_in || (region_in == RG_NONE) ||
                     (bus.i_lsu_wren && (region_in == RG_SW));
  assign be_in     = byte_en(size_in, bus.i_lsu_addr[1:0]);
  assign wd_in     = lane_data(size_in, bus.i_st_data);
  assign do_wr     = accept && bus.i_lsu_wren && !err_in;

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Capture the request at acceptance; later input changes are ignored.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) cap_q <= '0;
    else if (accept) begin
      cap_q.addr    <= bus.i_lsu_addr;
      cap_q.size    <= size_in;
      cap_q.uns     <= bus.i_lsu_unsigned;
      cap_q.wren    <= bus.i_lsu_wren;
      cap_q.st_data <= bus.i_st_data;
      cap_q.region  <= region_in;
      cap_q.err     <= err_in;
    end
  end

  // IO register stores, lane-merged, committed on the acceptance edge.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ledr_q  <= '0;
      ledg_q  <= '0;
      hexlo_q <= '0;
      hexhi_q <= '0;
      lcd_q   <= '0;
    end else if (do_wr) begin
      case (region_in)
        RG_LEDR:  ledr_q  <= merge(ledr_q,  wd_in, be_in);
        RG_LEDG:  ledg_q  <= merge(ledg_q,  wd_in, be_in);
        RG_HEXLO: hexlo_q <= merge(hexlo_q, wd_in, be_in);
        RG_HEXHI: hexhi_q <= merge(hexhi_q, wd_in, be_in);
        RG_LCD:   lcd_q   <= merge(lcd_q,   wd_in, be_in);
        default: ;
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous switches.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= i_io_sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  dmem_bytelane #(.DMEM_WORDS(DMEM_WORDS), .AW(AW)) u_dmem (
    .clk   (i_clk),
    .en    (accept),
    .we    (do_wr && (region_in == RG_DMEM)),
    .be    (be_in),
    .addr  (bus.i_lsu_addr[AW+1:2]),
    .wdata (wd_in),
    .rdata (dmem_rdata)
  );

  // Next state and response; outputs stay zero outside RESP.
  always_comb begin
    logic [31:0] src;
    state_d       = state_q;
    bus.o_rsp_vld = 1'b0;
    bus.o_rsp_err = 1'b0;
    bus.o_ld_data = '0;
    src           = '0;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RESP;
      ST_RESP: begin
        state_d       = ST_IDLE;
        bus.o_rsp_vld = 1'b1;
        bus.o_rsp_err = cap_q.err;
        case (cap_q.region)
          RG_DMEM:  src = dmem_rdata;
          RG_LEDR:  src = ledr_q;
          RG_LEDG:  src = ledg_q;
          RG_HEXLO: src = hexlo_q;
          RG_HEXHI: src = hexhi_q;
          RG_LCD:   src = lcd_q;
          RG_SW:    src = sw_sync_q;
          default:  src = '0;
        endcase
        if (!cap_q.err && !cap_q.wren)
          bus.o_ld_data = load_ext(src, cap_q.addr[1:0], cap_q.size, cap_q.uns);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_req_rdy = (state_q == ST_IDLE);
  assign o_io_ledr     = ledr_q;
  assign o_io_ledg     = ledg_q;
  assign o_io_lcd      = lcd_q;

  // Digit k shows byte lane k mod 4 of the low or high HEX register.
  for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex
    if (k < 4)      assign o_io_hex[k] = hexlo_q[(k % 4)*8 +: 7];
    else if (k < 8) assign o_io_hex[k] = hexhi_q[(k % 4)*8 +: 7];
    else            assign o_io_hex[k] = '0;
  end

  // Captured fields kept for visibility but not needed by the response path.
  logic unused_cap;
  assign unused_cap = ^{cap_q.addr[31:2], cap_q.st_data};

endmodule

// File: tb/tb_lsu_sized.sv
// Directed vector bench for lsu_sized.
module tb_lsu_sized;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] sw_in = '0;
  logic [31:0] ledr, ledg, lcd;
  logic [7:0][6:0] hex;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_sized_if bus ();

  lsu_sized #(.DMEM_WORDS(2048), .NUM_HEX(8)) dut (
    .i_clk    (clk),
    .i_reset  (rst_n),
    .bus      (bus.slave),
    .o_io_ledr(ledr),
    .o_io_ledg(ledg),
    .o_io_lcd (lcd),
    .o_io_hex (hex),
    .i_io_sw  (sw_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wren;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] a, input logic w, input logic [1:0] s, input logic u,
                     input logic [31:0] wd, input logic [31:0] ed, input logic ee);
    vec_t v;
    v.addr = a; v.wren = w; v.size = s; v.uns = u; v.wdata = wd;
    v.exp_data = ed; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  // One access: present at negedge, accepted at next posedge, sample in RESP,
  // then confirm the response lasts one cycle and outputs idle at zero.
  task automatic do_req(input logic [31:0] a, input logic w, input logic [1:0] s,
                        input logic u, input logic [31:0] wd,
                        output logic v, output logic [31:0] d, output logic e);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.o_req_rdy && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n == 8) chk("req_rdy_timeout", 32'(bus.o_req_rdy), 32'd1);
    bus.i_req_vld = 1'b1; bus.i_lsu_addr = a; bus.i_lsu_wren = w;
    bus.i_lsu_size = s; bus.i_lsu_unsigned = u; bus.i_st_data = wd;
    @(posedge clk);
    #1;
    bus.i_req_vld = 1'b0; bus.i_lsu_addr = 32'hFFFF_FFFF; bus.i_lsu_wren = ~w;
    bus.i_lsu_size = 2'b11; bus.i_lsu_unsigned = ~u; bus.i_st_data = ~wd;
    #1;
    v = bus.o_rsp_vld; d = bus.o_ld_data; e = bus.o_rsp_err;
    @(posedge clk);
    #1;
    chk("rsp_one_cycle", {bus.o_ld_data[30:0], bus.o_rsp_err | bus.o_rsp_vld}, 32'd0);
  endtask

  initial begin
    logic        v, e;
    logic [31:0] d;

    bus.i_req_vld = 1'b0; bus.i_lsu_addr = '0; bus.i_lsu_wren = 1'b0;
    bus.i_lsu_size = 2'b00; bus.i_lsu_unsigned = 1'b0; bus.i_st_data = '0;

    // addr, wren, size, uns, wdata, exp_data, exp_err
    add(32'h0000_0010, 1, 2'b10, 0, 32'hDEAD_BEEF, 32'h0, 0);
    add(32'h0000_0010, 0, 2'b10, 0, 32'h0,         32'hDEAD_BEEF, 0);
    add(32'h0000_0013, 1, 2'b00, 0, 32'h0000_0080, 32'h0, 0);
    add(32'h0000_0013, 0, 2'b00, 0, 32'h0,         32'hFFFF_FF80, 0);
    add(32'h0000_0013, 0, 2'b00, 1, 32'h0,         32'h0000_0080, 0);
    add(32'h0000_0010, 0, 2'b10, 0, 32'h0,         32'h80AD_BEEF, 0);
    add(32'h0000_0012, 0, 2'b01, 0, 32'h0,         32'hFFFF_80AD, 0);
    add(32'h0000_0012, 0, 2'b01, 1, 32'h0,         32'h0000_80AD, 0);
    add(32'h0000_0011, 0, 2'b00, 0, 32'h0,         32'hFFFF_FFBE, 0);
    add(32'h0000_0001, 0, 2'b01, 0, 32'h0,         32'h0, 1);
    add(32'h0000_0000, 1, 2'b10, 0, 32'h1122_3344, 32'h0, 0);
    add(32'h0000_0002, 1, 2'b10, 0, 32'hAABB_CCDD, 32'h0, 1);
    add(32'h0000_0000, 0, 2'b10, 0, 32'h0,         32'h1122_3344, 0);
    add(32'h0000_0010, 0, 2'b11, 0, 32'h0,         32'h0, 1);
    add(32'h0000_2000, 0, 2'b10, 0, 32'h0,         32'h0, 1);
    add(32'h0000_1FFC, 1, 2'b10, 0, 32'hABCD_0123, 32'h0, 0);
    add(32'h0000_1FFC, 0, 2'b10, 0, 32'h0,         32'hABCD_0123, 0);
    add(32'h2000_0000, 0, 2'b10, 0, 32'h0,         32'h0, 1);
    add(32'h1000_3000, 1, 2'b10, 0, 32'h0706_0504, 32'h0, 0);
    add(32'h1000_3000, 0, 2'b10, 0, 32'h0,         32'h0706_0504, 0);
    add(32'h1000_3002, 0, 2'b01, 1, 32'h0,         32'h0000_0706, 0);
    add(32'h1000_0002, 1, 2'b01, 0, 32'h1234_FFFF, 32'h0, 0);
    add(32'h1000_0000, 0, 2'b10, 0, 32'h0,         32'hFFFF_0000, 0);
    add(32'h1000_0002, 0, 2'b01, 0, 32'h0,         32'hFFFF_FFFF, 0);
    add(32'h1000_0001, 0, 2'b10, 0, 32'h0,         32'h0, 1);
    add(32'h1001_0000, 1, 2'b10, 0, 32'h1234_5678, 32'h0, 1);
    add(32'h1000_1001, 1, 2'b00, 0, 32'h0000_005A, 32'h0, 0);
    add(32'h1000_1000, 0, 2'b10, 0, 32'h0,         32'h0000_5A00, 0);
    add(32'h1000_4004, 0, 2'b10, 0, 32'h0,         32'h0, 1);
    add(32'h1000_4000, 1, 2'b10, 0, 32'hCAFE_F00D, 32'h0, 0);
    add(32'h1000_4000, 0, 2'b10, 0, 32'h0,         32'hCAFE_F00D, 0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_vld", 32'(bus.o_rsp_vld), 32'd0);
    chk("rst_req_rdy", 32'(bus.o_req_rdy), 32'd1);
    chk("rst_ld_data", bus.o_ld_data, 32'd0);
    chk("rst_ledr", ledr, 32'd0);
    chk("rst_lcd", lcd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven accesses.
    for (int i = 0; i < vecs.size(); i++) begin
      do_req(vecs[i].addr, vecs[i].wren, vecs[i].size, vecs[i].uns, vecs[i].wdata, v, d, e);
      chk($sformatf("vec%0d_vld", i), 32'(v), 32'd1);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
    end

    // IO outputs after the table.
    chk("hex4", 32'(hex[4]), 32'h04);
    chk("hex5", 32'(hex[5]), 32'h05);
    chk("hex6", 32'(hex[6]), 32'h06);
    chk("hex7", 32'(hex[7]), 32'h07);
    chk("hex0", 32'(hex[0]), 32'h00);
    chk("ledr", ledr, 32'hFFFF_0000);
    chk("ledg", ledg, 32'h0000_5A00);
    chk("lcd",  lcd,  32'hCAFE_F00D);

    // Switch synchronizer: first read right after the change sees the old value.
    sw_in = 32'h0000_00A5;
    do_req(32'h1001_0000, 0, 2'b10, 0, 32'h0, v, d, e);
    chk("sw_early_data", d, 32'h0);
    do_req(32'h1001_0000, 0, 2'b10, 0, 32'h0, v, d, e);
    chk("sw_late_vld", 32'(v), 32'd1);
    chk("sw_late_data", d, 32'h0000_00A5);

    // Reset asserted during RESP of a load.
    @(negedge clk);
    bus.i_req_vld = 1'b1; bus.i_lsu_addr = 32'h0000_0010; bus.i_lsu_wren = 1'b0;
    bus.i_lsu_size = 2'b10; bus.i_lsu_unsigned = 1'b0;
    @(posedge clk);
    #1;
    bus.i_req_vld = 1'b0;
    chk("pre_rst_in_resp", 32'(bus.o_req_rdy), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_vld", 32'(bus.o_rsp_vld), 32'd0);
    chk("midrst_req_rdy", 32'(bus.o_req_rdy), 32'd1);
    chk("midrst_ledr", ledr, 32'd0);
    chk("midrst_ledg", ledg, 32'd0);
    chk("midrst_lcd", lcd, 32'd0);
    chk("midrst_hex_hi", 32'(hex[7:4]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_rsp_vld", 32'(bus.o_rsp_vld), 32'd0);
    chk("postrst_req_rdy", 32'(bus.o_req_rdy), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
